// File: rtl/game_ctrl.sv
// Game-flow controller: IDLE/PLAY/DEAD sequencing, BCD score with high score,
// grace window after start, and the game-over flash, all advanced per video frame.
module game_ctrl #(
  parameter int unsigned GRACE_FRAMES = 30,
  parameter int unsigned DEAD_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame,
  input  logic       start,
  input  logic       hit,
  input  logic       in_gap,
  input  logic       inc_score,
  output logic       playing,
  output logic       game_over,
  output logic       freeze,
  output logic       flash,
  output logic [7:0] score,
  output logic [7:0] hi_score,
  output logic       score_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2
  } state_e;

  localparam logic [7:0] GRACE_INIT = 8'(GRACE_FRAMES);
  localparam logic [7:0] DEAD_INIT  = 8'(DEAD_FRAMES);
  localparam logic [7:0] BLINK_INIT = 8'(BLINK_FRAMES);
  localparam logic [7:0] SCORE_MAX  = 8'h99;

  state_e     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [7:0] hi_score_q, hi_score_d;
  logic [7:0] grace_q, grace_d;
  logic [7:0] dead_q, dead_d;
  logic [7:0] blink_q, blink_d;
  logic       flash_q, flash_d;
  logic       score_pulse_q, score_pulse_d;
  logic       start_q;
  logic       inc_prev_q, inc_prev_d;

  logic start_rise;
  logic collision;
  logic score_event;

  // Saturating two-digit BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == SCORE_MAX) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d       = state_q;
    score_d       = score_q;
    hi_score_d    = hi_score_q;
    grace_d       = grace_q;
    dead_d        = dead_q;
    blink_d       = blink_q;
    flash_d       = flash_q;
    score_pulse_d = 1'b0;
    inc_prev_d    = frame ? inc_score : inc_prev_q;
    start_rise    = start & ~start_q;
    collision     = 1'b0;
    score_event   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d    = S_PLAY;
          score_d    = 8'h00;
          grace_d    = GRACE_INIT;
          inc_prev_d = 1'b0;
        end
      end

      S_PLAY: begin
        if (frame) begin
          // Collisions are judged against the grace count held before this frame's decrement.
          collision   = hit & ~in_gap & (grace_q == 8'd0);
          score_event = inc_score & ~inc_prev_q;
          if (grace_q != 8'd0) begin
            grace_d = grace_q - 8'd1;
          end
          if (collision) begin
            state_d = S_DEAD;
            if (score_q > hi_score_q) begin
              hi_score_d = score_q;
            end
            dead_d  = DEAD_INIT;
            blink_d = BLINK_INIT;
            flash_d = 1'b1;
          end else if (score_event && score_q != SCORE_MAX) begin
            score_d       = bcd_inc(score_q);
            score_pulse_d = 1'b1;
          end
        end
      end

      S_DEAD: begin
        if (frame) begin
          if (dead_q != 8'd0) begin
            dead_d = dead_q - 8'd1;
          end
          if (blink_q == 8'd1) begin
            blink_d = BLINK_INIT;
            flash_d = ~flash_q;
          end else begin
            blink_d = blink_q - 8'd1;
          end
        end
        // Restart only once the dead window has fully elapsed.
        if (start_rise && dead_q == 8'd0) begin
          state_d    = S_PLAY;
          score_d    = 8'h00;
          grace_d    = GRACE_INIT;
          inc_prev_d = 1'b0;
          flash_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      score_q       <= 8'h00;
      hi_score_q    <= 8'h00;
      grace_q       <= 8'd0;
      dead_q        <= 8'd0;
      blink_q       <= 8'd0;
      flash_q       <= 1'b0;
      score_pulse_q <= 1'b0;
      start_q       <= 1'b0;
      inc_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      hi_score_q    <= hi_score_d;
      grace_q       <= grace_d;
      dead_q        <= dead_d;
      blink_q       <= blink_d;
      flash_q       <= flash_d;
      score_pulse_q <= score_pulse_d;
      start_q       <= start;
      inc_prev_q    <= inc_prev_d;
    end
  end

  assign playing     = (state_q == S_PLAY);
  assign game_over   = (state_q == S_DEAD);
  assign freeze      = (state_q != S_PLAY);
  assign flash       = flash_q;
  assign score       = score_q;
  assign hi_score    = hi_score_q;
  assign score_pulse = score_pulse_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: reset, scoring, grace window, gap handling,
// BCD rollover/saturation, dead-time blink and restart rules.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame;
  logic       start;
  logic       hit;
  logic       in_gap;
  logic       inc_score;
  logic       playing;
  logic       game_over;
  logic       freeze;
  logic       flash;
  logic [7:0] score;
  logic [7:0] hi_score;
  logic       score_pulse;

  int   errors    = 0;
  int   checks    = 0;
  int   pulse_cnt = 0;
  logic pulse_seen;

  typedef struct {
    logic       hit;
    logic       gap;
    logic       inc;
    logic       exp_play;
    logic       exp_over;
    logic       exp_pulse;
    logic [7:0] exp_score;
  } vec_t;

  vec_t tbl[23];

  game_ctrl #(
    .GRACE_FRAMES(30),
    .DEAD_FRAMES (120),
    .BLINK_FRAMES(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame      (frame),
    .start      (start),
    .hit        (hit),
    .in_gap     (in_gap),
    .inc_score  (inc_score),
    .playing    (playing),
    .game_over  (game_over),
    .freeze     (freeze),
    .flash      (flash),
    .score      (score),
    .hi_score   (hi_score),
    .score_pulse(score_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {7'd0, act}, {7'd0, exp});
  endtask

  // One frame pulse carrying the given inputs, then one quiet cycle.
  task automatic do_frame(input logic h, input logic g, input logic s);
    @(negedge clk);
    frame = 1'b1; hit = h; in_gap = g; inc_score = s;
    @(posedge clk); #1;
    pulse_seen = score_pulse;
    if (score_pulse) pulse_cnt++;
    @(negedge clk);
    frame = 1'b0; hit = 1'b0; in_gap = 1'b0; inc_score = 1'b0;
    @(posedge clk); #1;
    if (score_pulse) pulse_cnt++;
  endtask

  task automatic press_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    logic p;
    rst = 1'b1; frame = 1'b0; start = 1'b0;
    hit = 1'b0; in_gap = 1'b0; inc_score = 1'b0;

    for (int i = 0; i < 20; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check_bit("reset freeze", freeze, 1'b1);
    check_bit("reset playing", playing, 1'b0);
    check_bit("reset game_over", game_over, 1'b0);
    check_bit("reset flash", flash, 1'b0);
    check_bit("reset pulse", score_pulse, 1'b0);
    check("reset score", score, 8'h00);
    check("reset hi_score", hi_score, 8'h00);

    // Game 1: reach 0x05 then reset asynchronously mid-game.
    press_start();
    check_bit("g1 playing", playing, 1'b1);
    check_bit("g1 freeze", freeze, 1'b0);
    for (int i = 1; i <= 20; i++) do_frame(1'b0, 1'b0, (i % 4) == 0);
    check("g1 score", score, 8'h05);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_bit("async rst playing", playing, 1'b0);
    check_bit("async rst freeze", freeze, 1'b1);
    check("async rst score", score, 8'h00);
    check("async rst hi_score", hi_score, 8'h00);
    check_bit("async rst flash", flash, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Game 2: scoring over 40 frames with collisions inside the grace window.
    pulse_cnt = 0;
    press_start();
    for (int i = 1; i <= 40; i++) begin
      do_frame((i == 5) || (i == 29), 1'b0, (i % 4) == 0);
      check_bit("g2 playing", playing, 1'b1);
    end
    check("g2 score", score, 8'h10);
    check("g2 pulse count", 8'(pulse_cnt), 8'd10);

    for (int i = 0; i < 23; i++) begin
      do_frame(tbl[i].hit, tbl[i].gap, tbl[i].inc);
      check_bit($sformatf("vec%0d playing", i), playing, tbl[i].exp_play);
      check_bit($sformatf("vec%0d game_over", i), game_over, tbl[i].exp_over);
      check_bit($sformatf("vec%0d pulse", i), pulse_seen, tbl[i].exp_pulse);
      check($sformatf("vec%0d score", i), score, tbl[i].exp_score);
    end
    check("g2 hi_score", hi_score, 8'h11);
    check_bit("g2 dead flash", flash, 1'b1);
    check_bit("g2 dead freeze", freeze, 1'b1);

    // Dead window: blink cadence and restart gating.
    for (int k = 1; k <= 120; k++) begin
      do_frame(1'b0, 1'b0, 1'b0);
      if (k == 14 || k == 15 || k == 29 || k == 30 || k == 45 || k == 120)
        check_bit($sformatf("flash after %0d", k), flash, ((k / 15) % 2) == 0);
      if (k == 60 || k == 119) begin
        press_start();
        check_bit($sformatf("start ignored at %0d", k), game_over, 1'b1);
      end
    end
    press_start();
    check_bit("restart playing", playing, 1'b1);
    check("restart score", score, 8'h00);
    check("restart hi_score", hi_score, 8'h11);
    check_bit("restart flash", flash, 1'b0);

    // Game 3: BCD rollover and saturation.
    pulse_cnt = 0;
    for (int e = 1; e <= 100; e++) begin
      do_frame(1'b0, 1'b0, 1'b1);
      p = pulse_seen;
      do_frame(1'b0, 1'b0, 1'b0);
      if (e == 9)  check("bcd 9 events", score, 8'h09);
      if (e == 10) begin
        check("bcd rollover", score, 8'h10);
        check_bit("bcd rollover pulse", p, 1'b1);
      end
      if (e == 99) check("bcd 99 events", score, 8'h99);
      if (e == 100) begin
        check("bcd saturate", score, 8'h99);
        check_bit("bcd saturate pulse", p, 1'b0);
      end
    end
    check("g3 pulse count", 8'(pulse_cnt), 8'd99);
    do_frame(1'b1, 1'b0, 1'b0);
    check_bit("g3 game_over", game_over, 1'b1);
    check("g3 hi_score", hi_score, 8'h99);
    for (int k = 1; k <= 120; k++) do_frame(1'b0, 1'b0, 1'b0);
    press_start();
    check_bit("g4 playing", playing, 1'b1);

    // Game 4: grace boundary and a lower score that must not touch hi_score.
    for (int i = 1; i <= 31; i++) begin
      do_frame((i == 30) || (i == 31), 1'b0, i == 2);
      if (i == 30) check_bit("grace frame 30", playing, 1'b1);
    end
    check_bit("frame 31 game_over", game_over, 1'b1);
    check("g4 score", score, 8'h01);
    check("g4 hi_score kept", hi_score, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
